// File: rtl/multdiv_seq_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   md_state_e : FSM encodings (idle, iterating, result-ready)
//   md_op_e    : operation selector latched on start
//   MD_WIDTH   : default operand/result width
//   INT_MIN    : most negative operand, used for the INT_MIN / -1 check
package multdiv_seq_unit_pkg;

   localparam int unsigned MD_WIDTH = 32;
   localparam logic [MD_WIDTH-1:0] INT_MIN = 32'h8000_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } md_state_e;

   typedef enum logic {
      OP_MULT = 1'b0,
      OP_DIV  = 1'b1
   } md_op_e;

endpackage

// File: rtl/multdiv_seq_unit_if.sv
// Handshake/data bundle between the execute stage and the multiply/divide unit.
//   master : issues start pulses and operands, receives result/exception/ready/busy
//   slave  : the unit itself
interface multdiv_seq_unit_if #(
   parameter int unsigned WIDTH = 32
);
   logic             ctrl_MULT;
   logic             ctrl_DIV;
   logic [WIDTH-1:0] data_operandA;
   logic [WIDTH-1:0] data_operandB;
   logic [WIDTH-1:0] data_result;
   logic             data_exception;
   logic             data_resultRDY;
   logic             busy;

   modport master (
      output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
      input  data_result, data_exception, data_resultRDY, busy
   );

   modport slave (
      input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
      output data_result, data_exception, data_resultRDY, busy
   );
endinterface

// File: rtl/multdiv_seq_unit_cond_negate.sv
// Conditional two's-complement negation.
//   data_i : value to pass through or negate
//   neg_i  : 1 = output -data_i, 0 = output data_i
//   data_o : result (same width)
module multdiv_seq_unit_cond_negate #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] data_i,
   input  logic             neg_i,
   output logic [WIDTH-1:0] data_o
);
   // Invert-and-increment folded into one add: (x ^ m) + neg.
   assign data_o = (data_i ^ {WIDTH{neg_i}}) + WIDTH'(neg_i);
endmodule

// File: rtl/multdiv_seq_unit.sv
// Iterative signed multiply / restoring divide, one bit per cycle.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus          : start pulses, operands, result, exception, ready pulse, busy
// Operands are reduced to magnitudes on start; the sign is re-applied on the
// final iteration so the result, exception and ready pulse are all registered.
module multdiv_seq_unit
   import multdiv_seq_unit_pkg::*;
#(
   parameter int unsigned WIDTH = MD_WIDTH
) (
   input  logic              clock,
   input  logic              reset,
   multdiv_seq_unit_if.slave bus
);
   localparam int unsigned CntW = $clog2(WIDTH);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   md_state_e          state_q, state_d;
   md_op_e             op_q, op_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic               sign_q, sign_d;
   logic               b_zero_q, b_zero_d;
   logic               min_neg1_q, min_neg1_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               exc_q, exc_d;
   logic               rdy_q, rdy_d;
   logic               busy_q, busy_d;

   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     mul_sum, div_diff;
   logic [2*WIDTH-1:0] mul_next, div_next, step, res_mag, res_signed;
   logic               start, mul_ovf;

   multdiv_seq_unit_cond_negate #(.WIDTH(WIDTH)) u_mag_a (
      .data_i (bus.data_operandA),
      .neg_i  (bus.data_operandA[WIDTH-1]),
      .data_o (mag_a)
   );

   multdiv_seq_unit_cond_negate #(.WIDTH(WIDTH)) u_mag_b (
      .data_i (bus.data_operandB),
      .neg_i  (bus.data_operandB[WIDTH-1]),
      .data_o (mag_b)
   );

   // Multiply: acc = {partial product, remaining multiplier bits}.
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

   // Restoring divide: acc = {remainder, dividend bits / quotient bits}.
   assign div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
   assign div_next = div_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

   assign step    = (op_q == OP_DIV) ? div_next : mul_next;
   assign res_mag = (op_q == OP_DIV) ? {{WIDTH{1'b0}}, step[WIDTH-1:0]} : step;

   multdiv_seq_unit_cond_negate #(.WIDTH(2*WIDTH)) u_fix_sign (
      .data_i (res_mag),
      .neg_i  (sign_q),
      .data_o (res_signed)
   );

   // Product fits in WIDTH signed bits only if the top WIDTH+1 bits agree.
   assign mul_ovf = ~((&res_signed[2*WIDTH-1:WIDTH-1]) | ~(|res_signed[2*WIDTH-1:WIDTH-1]));

   assign start = (state_q != ST_RUN) && (bus.ctrl_MULT || bus.ctrl_DIV);

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      opb_d      = opb_q;
      sign_d     = sign_q;
      b_zero_d   = b_zero_q;
      min_neg1_d = min_neg1_q;
      result_d   = result_q;
      exc_d      = exc_q;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d    = ST_RUN;
               op_d       = bus.ctrl_MULT ? OP_MULT : OP_DIV;
               cnt_d      = '0;
               acc_d      = {{WIDTH{1'b0}}, mag_a};
               opb_d      = mag_b;
               sign_d     = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
               b_zero_d   = (bus.data_operandB == '0);
               min_neg1_d = (bus.data_operandA == WIDTH'(INT_MIN)) && (&bus.data_operandB);
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            acc_d = step;
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == LastCnt) begin
               state_d = ST_DONE;
               if (op_q == OP_MULT) begin
                  result_d = res_signed[WIDTH-1:0];
                  exc_d    = mul_ovf;
               end else if (b_zero_q) begin
                  result_d = '0;
                  exc_d    = 1'b1;
               end else if (min_neg1_q) begin
                  result_d = WIDTH'(INT_MIN);
                  exc_d    = 1'b1;
               end else begin
                  result_d = res_signed[WIDTH-1:0];
                  exc_d    = 1'b0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d == ST_RUN);
      rdy_d  = (state_d == ST_DONE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         op_q       <= OP_MULT;
         cnt_q      <= '0;
         acc_q      <= '0;
         opb_q      <= '0;
         sign_q     <= 1'b0;
         b_zero_q   <= 1'b0;
         min_neg1_q <= 1'b0;
         result_q   <= '0;
         exc_q      <= 1'b0;
         rdy_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         opb_q      <= opb_d;
         sign_q     <= sign_d;
         b_zero_q   <= b_zero_d;
         min_neg1_q <= min_neg1_d;
         result_q   <= result_d;
         exc_q      <= exc_d;
         rdy_q      <= rdy_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.data_result    = result_q;
   assign bus.data_exception = exc_q;
   assign bus.data_resultRDY = rdy_q;
   assign bus.busy           = busy_q;

endmodule

// File: tb/tb_multdiv_seq_unit.sv
// Directed-vector bench for multdiv_seq_unit with hand-computed results.
module tb_multdiv_seq_unit;

   logic clock;
   logic reset;
   int   n_vec;
   int   n_bad;

   multdiv_seq_unit_if #(.WIDTH(32)) mif ();

   multdiv_seq_unit #(.WIDTH(32)) u_dut (
      .clock (clock),
      .reset (reset),
      .bus   (mif.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called 1ns after a rising edge; returns 1ns after the edge that samples the start.
   task automatic start_op(input logic mult, input logic [31:0] a, input logic [31:0] b);
      mif.ctrl_MULT     = mult;
      mif.ctrl_DIV      = ~mult;
      mif.data_operandA = a;
      mif.data_operandB = b;
      @(posedge clock);
      #1;
      mif.ctrl_MULT = 1'b0;
      mif.ctrl_DIV  = 1'b0;
   endtask

   // Issue one operation and wait (bounded) for its ready pulse; stays in the ready cycle.
   task automatic run_op(input string tag, input logic mult, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_r, input logic exp_e);
      int n;
      int nbusy;
      start_op(mult, a, b);
      n     = 0;
      nbusy = 0;
      while (!mif.data_resultRDY && n < 40) begin
         if (mif.busy) nbusy++;
         @(posedge clock);
         #1;
         n++;
      end
      check({tag, "_lat"}, 64'(n), 64'd32);
      check({tag, "_busy_cycles"}, 64'(nbusy), 64'd32);
      check({tag, "_rdy"}, 64'(mif.data_resultRDY), 64'd1);
      check({tag, "_busy_at_rdy"}, 64'(mif.busy), 64'd0);
      check({tag, "_result"}, 64'(mif.data_result), 64'(exp_r));
      check({tag, "_exc"}, 64'(mif.data_exception), 64'(exp_e));
   endtask

   // Ready must be a single-cycle pulse while the result stays put.
   task automatic check_after(input string tag, input logic [31:0] exp_r, input logic exp_e);
      @(posedge clock);
      #1;
      check({tag, "_rdy_drop"}, 64'(mif.data_resultRDY), 64'd0);
      check({tag, "_hold_result"}, 64'(mif.data_result), 64'(exp_r));
      check({tag, "_hold_exc"}, 64'(mif.data_exception), 64'(exp_e));
   endtask

   initial begin
      int n;
      int n_rdy;
      n_vec = 0;
      n_bad = 0;
      mif.ctrl_MULT     = 1'b0;
      mif.ctrl_DIV      = 1'b0;
      mif.data_operandA = '0;
      mif.data_operandB = '0;
      reset             = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      check("reset_result", 64'(mif.data_result), 64'd0);
      check("reset_exc", 64'(mif.data_exception), 64'd0);
      check("reset_rdy", 64'(mif.data_resultRDY), 64'd0);
      check("reset_busy", 64'(mif.busy), 64'd0);

      run_op("mul_7_m3", 1'b1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
      check_after("mul_7_m3", 32'hFFFF_FFEB, 1'b0);
      run_op("mul_ovf", 1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
      check_after("mul_ovf", 32'h0000_0000, 1'b1);
      run_op("mul_min_1", 1'b1, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);
      run_op("mul_m1_m1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0);
      run_op("div_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
      run_op("div_100_m7", 1'b0, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0);
      run_op("div_5_0", 1'b0, 32'd5, 32'd0, 32'd0, 1'b1);
      check_after("div_5_0", 32'd0, 1'b1);
      run_op("div_min_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
      check_after("div_min_m1", 32'h8000_0000, 1'b1);

      // Back-to-back: second start lands in the DONE cycle of the first.
      run_op("b2b_first", 1'b1, 32'd6, 32'd7, 32'd42, 1'b0);
      run_op("b2b_second", 1'b1, 32'd2, 32'd3, 32'd6, 1'b0);

      // Start ignored during RUN, then reset aborts the operation.
      start_op(1'b1, 32'd3, 32'd4);
      repeat (4) @(posedge clock);
      #1;
      start_op(1'b0, 32'd100, 32'd5);
      check("abort_busy_mid", 64'(mif.busy), 64'd1);
      repeat (4) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      check("abort_busy", 64'(mif.busy), 64'd0);
      check("abort_result", 64'(mif.data_result), 64'd0);
      check("abort_exc", 64'(mif.data_exception), 64'd0);
      n_rdy = 0;
      for (n = 0; n < 40; n++) begin
         if (mif.data_resultRDY) n_rdy++;
         @(posedge clock);
         #1;
      end
      check("abort_no_rdy", 64'(n_rdy), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/multdiv_seq_unit.md
Name: multdiv_seq_unit

Overview:
- Iterative signed 32-bit multiply/divide unit instantiated in the execute stage of the 5-stage pipeline.
- Accepts a one-cycle start pulse for MULT or DIV and latches the operands.
- Computes the result over a fixed number of cycles, holding `busy` high so pipeline stall logic freezes F/D/X/M/W latches.
- Presents the result with a one-cycle ready pulse and exception flag for writeback to $rd or $rstatus.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clock  in  1  master clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- ctrl_MULT  in  1  start-multiply pulse.
- ctrl_DIV  in  1  start-divide pulse.
- data_operandA  in  WIDTH  multiplicand / dividend; sampled only on an accepted start.
- data_operandB  in  WIDTH  multiplier / divisor; sampled only on an accepted start.
- data_result  out  WIDTH  product low word or quotient.
- data_exception  out  1  overflow, divide-by-zero or INT_MIN/-1.
- data_resultRDY  out  1  one-cycle pulse; data_result and data_exception are valid.
- busy  out  1  operation in flight; drives pipeline stall.

Behaviour:
- States: IDLE, RUN, DONE. 5-bit iteration counter; 64-bit accumulator/remainder register; op flag; sign flag.
- Reset (synchronous):
  - State goes to IDLE and the counter clears.
  - data_result=0, data_exception=0, data_resultRDY=0, busy=0.
  - Reset overrides any in-flight operation; no ready pulse is produced for the aborted operation.
- Start acceptance: only in IDLE or DONE.
  - ctrl_MULT has priority if both starts are high.
  - Starts arriving while in RUN are ignored and not queued.
- IDLE or DONE with an accepted start:
  - Latch the magnitudes of A and B, the result sign (A[31]^B[31]), the op type, and the raw operand values for exception checks.
  - counter=0. Next state is RUN.
- RUN: one shift-add (MULT) or one restoring shift-subtract (DIV) step per cycle.
  - After the step with counter==WIDTH-1, next state is DONE.
  - busy=1 for every RUN cycle.
- DONE:
  - data_resultRDY=1 and busy=0 for exactly this one cycle.
  - The result is applied with sign correction.
  - DONE then moves to IDLE unless a new start is accepted.
- Latency: start sampled on edge E; RUN occupies edges E+1..E+32; data_resultRDY is high in the cycle following edge E+32, i.e. 33 cycles after the start cycle.
- data_result and data_exception hold their values after DONE until the next DONE or reset.
- MULT result: low 32 bits of the signed 64-bit product.
  - data_exception=1 iff the full product is not representable in signed 32 bits (upper 33 bits not all equal).
- DIV result: quotient truncated toward zero; remainder discarded.
  - Divisor 0: data_result=0, data_exception=1. The full latency is still taken (no early exit).
  - 0x80000000 / 0xFFFFFFFF: data_result=0x80000000, data_exception=1.
- Magnitude of 0x80000000 is handled as unsigned 0x80000000 in the 64-bit datapath; no overflow occurs internally.
- Arithmetic is two's complement throughout; all internal adders use WIDTH+1 bits for carry/borrow.

Decomposition:
- Shared package: state encodings (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2), op encodings (OP_MULT=1'b0, OP_DIV=1'b1), INT_MIN constant.
- Sub-module cond_negate: WIDTH-parameterised conditional two's-complement negation.
  - Instantiated for the operand-magnitude stage and the result sign-correction stage.
- The FSM and iteration datapath stay in the top module.

Test Plan:
- MULT 7 × 0xFFFFFFFD (-3) -> data_resultRDY=1 exactly 33 cycles after start, data_result=0xFFFFFFEB, data_exception=0, busy high for 32 cycles.
- MULT 0x00010000 × 0x00010000 -> data_result=0x00000000, data_exception=1.
- DIV 0xFFFFFFF9 (-7) ÷ 2 -> data_result=0xFFFFFFFD, data_exception=0.
- DIV 5 ÷ 0 -> RDY after 33 cycles, data_result=0, data_exception=1.
- DIV 0x80000000 ÷ 0xFFFFFFFF -> data_result=0x80000000, data_exception=1.
- Start MULT 3×4, pulse ctrl_DIV at cycle 5, assert reset at cycle 10 -> the DIV pulse is ignored; after reset, busy=0, data_result=0, and RDY never pulses.
- Issue MULT 6×7, then a new MULT 2×3 start in the DONE cycle -> first RDY shows 42; second RDY 33 cycles later shows 6, with no IDLE gap.
